// File: rtl/deserializer_lanes.sv
// Multi-lane serial-to-parallel deserializer with SOF framing and a valid/ready output register.
// Optional DESER_DROP_CNT_EN adds a saturating counter of dropped and abandoned words.
module deserializer_lanes #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned LANES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [LANES-1:0] iv_din,
    input  logic             i_sof,
    input  logic             i_msb_first,
    output logic [WIDTH-1:0] ov_dout,
    output logic             o_dout_valid,
    input  logic             i_dout_ready,
    output logic             o_overflow,
`ifdef DESER_DROP_CNT_EN
    output logic [15:0]      ov_drop_cnt,
`endif
    output logic             o_sync_err
);

    localparam int unsigned BEATS = WIDTH / LANES;
    localparam int unsigned CntW  = $clog2(BEATS + 1);

    typedef enum logic [0:0] {StHunt, StCollect} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] dout_q;
    logic             order_q;
    logic             done_q;
    logic             valid_q;
    logic             ovf_q;
    logic             sync_err_q;

    logic             use_msb;
    logic [WIDTH-1:0] sr_shift;
    logic             mid_sof;
    logic             word_drop;

    // A SOF beat uses the order bit it carries; later beats use the latched one.
    always_comb begin
        use_msb  = i_sof ? i_msb_first : order_q;
        sr_shift = use_msb ? {sr_q[WIDTH-LANES-1:0], iv_din}
                           : {iv_din, sr_q[WIDTH-1:LANES]};
    end

    assign mid_sof   = i_en && i_sof && (state_q == StCollect) && (cnt_q != '0);
    assign word_drop = done_q && valid_q && !i_dout_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StHunt;
            cnt_q      <= '0;
            sr_q       <= '0;
            dout_q     <= '0;
            order_q    <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            sync_err_q <= 1'b0;
            done_q     <= 1'b0;

            if (i_en) begin
                unique case (state_q)
                    StHunt: begin
                        if (i_sof) begin
                            sr_q    <= sr_shift;
                            order_q <= i_msb_first;
                            cnt_q   <= CntW'(1);
                            state_q <= StCollect;
                        end
                    end
                    StCollect: begin
                        if (i_sof) begin
                            sync_err_q <= mid_sof;
                            sr_q       <= sr_shift;
                            order_q    <= i_msb_first;
                            cnt_q      <= CntW'(1);
                        end else if (cnt_q == '0) begin
                            // Word boundary without SOF: framing lost.
                            sync_err_q <= 1'b1;
                            state_q    <= StHunt;
                        end else begin
                            sr_q <= sr_shift;
                            if (cnt_q == CntW'(BEATS - 1)) begin
                                cnt_q  <= '0;
                                done_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + CntW'(1);
                            end
                        end
                    end
                    default: state_q <= StHunt;
                endcase
            end

            // Output stage sees the completed word one edge after its last beat.
            if (done_q) begin
                if (word_drop) begin
                    ovf_q <= 1'b1;
                end else begin
                    dout_q  <= sr_q;
                    valid_q <= 1'b1;
                end
            end else if (valid_q && i_dout_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign ov_dout      = dout_q;
    assign o_dout_valid = valid_q;
    assign o_overflow   = ovf_q;
    assign o_sync_err   = sync_err_q;

`ifdef DESER_DROP_CNT_EN
    logic [15:0] drop_cnt_q;
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;

    always_comb begin
        drop_inc = {1'b0, mid_sof} + {1'b0, word_drop};
        drop_sum = {1'b0, drop_cnt_q} + {15'b0, drop_inc};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_cnt_q <= '0;
        end else if (drop_sum[16]) begin
            drop_cnt_q <= 16'hFFFF;
        end else begin
            drop_cnt_q <= drop_sum[15:0];
        end
    end

    assign ov_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_deserializer_lanes.sv
// Bench for deserializer_lanes: instance 0 is WIDTH=8/LANES=2, instance 1 is WIDTH=24/LANES=1.
// A word-level model predicts every output each cycle; literal checks pin the model.
module tb_deserializer_lanes;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic       en  [2];
    logic       sof [2];
    logic       msb [2];
    logic       rdy [2];
    logic [1:0] din_a;
    logic       din_b;

    logic [7:0]  dout_a;
    logic [23:0] dout_b;
    logic        valid [2];
    logic        ovf   [2];
    logic        serr  [2];
`ifdef DESER_DROP_CNT_EN
    logic [15:0] dcnt  [2];
`endif

    deserializer_lanes #(.WIDTH(8), .LANES(2)) u_dut_a (
        .i_clk        (clk),
        .i_rst        (rst[0]),
        .i_en         (en[0]),
        .iv_din       (din_a),
        .i_sof        (sof[0]),
        .i_msb_first  (msb[0]),
        .ov_dout      (dout_a),
        .o_dout_valid (valid[0]),
        .i_dout_ready (rdy[0]),
        .o_overflow   (ovf[0]),
`ifdef DESER_DROP_CNT_EN
        .ov_drop_cnt  (dcnt[0]),
`endif
        .o_sync_err   (serr[0])
    );

    deserializer_lanes #(.WIDTH(24), .LANES(1)) u_dut_b (
        .i_clk        (clk),
        .i_rst        (rst[1]),
        .i_en         (en[1]),
        .iv_din       (din_b),
        .i_sof        (sof[1]),
        .i_msb_first  (msb[1]),
        .ov_dout      (dout_b),
        .o_dout_valid (valid[1]),
        .i_dout_ready (rdy[1]),
        .o_overflow   (ovf[1]),
`ifdef DESER_DROP_CNT_EN
        .ov_drop_cnt  (dcnt[1]),
`endif
        .o_sync_err   (serr[1])
    );

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Word-level model: beats are collected in a list and assembled by arithmetic.
    bit          m_hunt  [2];
    int          m_nb    [2];
    logic [31:0] m_beats [2][32];
    bit          m_ord   [2];
    bit          m_pend  [2];
    logic [31:0] m_pword [2];
    logic [31:0] m_dout  [2];
    bit          m_valid [2];
    bit          m_ovf   [2];
    bit          m_serr  [2];
    int          m_drop  [2];

    task automatic bump_drop(input int m);
        if (m_drop[m] < 65535) m_drop[m]++;
    endtask

    task automatic add_beat(input int m, input logic [31:0] d, input int bw, input int lw);
        logic [31:0] w;
        m_beats[m][m_nb[m]] = d;
        m_nb[m]++;
        if (m_nb[m] == bw) begin
            w = '0;
            for (int k = 0; k < bw; k++) begin
                w = w | (m_beats[m][k] << (lw * (m_ord[m] ? (bw - 1 - k) : k)));
            end
            m_pword[m] = w;
            m_pend[m]  = 1'b1;
            m_nb[m]    = 0;
        end
    endtask

    task automatic model_step(input int m);
        int          bw;
        int          lw;
        logic [31:0] d;
        bit          new_word;
        lw = (m == 0) ? 2 : 1;
        bw = (m == 0) ? 4 : 24;
        d  = (m == 0) ? {30'b0, din_a} : {31'b0, din_b};
        if (rst[m]) begin
            m_hunt[m] = 1'b1; m_nb[m] = 0; m_pend[m] = 1'b0; m_dout[m] = '0;
            m_valid[m] = 1'b0; m_ovf[m] = 1'b0; m_serr[m] = 1'b0; m_drop[m] = 0;
            m_ord[m] = 1'b0;
            return;
        end
        m_serr[m] = 1'b0;
        new_word  = m_pend[m];
        m_pend[m] = 1'b0;
        if (new_word) begin
            if (m_valid[m] && !rdy[m]) begin
                m_ovf[m] = 1'b1;
                bump_drop(m);
            end else begin
                m_dout[m]  = m_pword[m];
                m_valid[m] = 1'b1;
            end
        end else if (m_valid[m] && rdy[m]) begin
            m_valid[m] = 1'b0;
        end
        if (en[m]) begin
            if (sof[m]) begin
                if (!m_hunt[m] && m_nb[m] != 0) begin
                    m_serr[m] = 1'b1;
                    bump_drop(m);
                end
                m_hunt[m] = 1'b0;
                m_nb[m]   = 0;
                m_ord[m]  = msb[m];
                add_beat(m, d, bw, lw);
            end else if (!m_hunt[m]) begin
                if (m_nb[m] == 0) begin
                    m_serr[m] = 1'b1;
                    m_hunt[m] = 1'b1;
                end else begin
                    add_beat(m, d, bw, lw);
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) model_step(m);
    end

    logic [23:0] words_b[$];
    int          serr_b = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("dout[%0d]", m),
                    (m == 0) ? {24'b0, dout_a} : {8'b0, dout_b}, m_dout[m]);
                chk($sformatf("valid[%0d]", m), {31'b0, valid[m]}, {31'b0, m_valid[m]});
                chk($sformatf("overflow[%0d]", m), {31'b0, ovf[m]}, {31'b0, m_ovf[m]});
                chk($sformatf("sync_err[%0d]", m), {31'b0, serr[m]}, {31'b0, m_serr[m]});
`ifdef DESER_DROP_CNT_EN
                chk($sformatf("drop_cnt[%0d]", m), {16'b0, dcnt[m]}, m_drop[m]);
`endif
            end
            if (valid[1] && rdy[1]) words_b.push_back(dout_b);
            if (serr[1]) serr_b++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat_a(input logic [1:0] d, input logic s, input logic o);
        en[0] = 1'b1; din_a = d; sof[0] = s; msb[0] = o;
        idle(1);
        en[0] = 1'b0; sof[0] = 1'b0;
    endtask

    task automatic word_a(input logic [7:0] w);
        for (int k = 0; k < 4; k++) beat_a(w[7-2*k -: 2], k == 0, 1'b1);
    endtask

    logic [23:0] exp_b [4];

    initial begin
        exp_b[0] = 24'h123456; exp_b[1] = 24'hABCDEF;
        exp_b[2] = 24'h800001; exp_b[3] = 24'hFFFFFF;
        for (int m = 0; m < 2; m++) begin
            rst[m] = 1'b1; en[m] = 1'b0; sof[m] = 1'b0; msb[m] = 1'b0; rdy[m] = 1'b0;
        end
        din_a = '0; din_b = 1'b0;
        idle(1);
        chk_on = 1'b1;
        chk("reset dout", {24'b0, dout_a}, 32'h0);
        chk("reset valid", {31'b0, valid[0]}, 32'h0);
        chk("reset overflow", {31'b0, ovf[0]}, 32'h0);
        idle(1);
        rst[0] = 1'b0; rst[1] = 1'b0;
        idle(1);

        // 1: MSB-first 10,10,01,01 -> A5
        beat_a(2'b10, 1'b1, 1'b1); beat_a(2'b10, 1'b0, 1'b0);
        beat_a(2'b01, 1'b0, 1'b0); beat_a(2'b01, 1'b0, 1'b0);
        chk("t1 valid before latency", {31'b0, valid[0]}, 32'h0);
        idle(1);
        chk("t1 dout", {24'b0, dout_a}, 32'hA5);
        chk("t1 valid", {31'b0, valid[0]}, 32'h1);
        rdy[0] = 1'b1; idle(1); rdy[0] = 1'b0;
        chk("t1 drained", {31'b0, valid[0]}, 32'h0);

        // 2: LSB-first 01,01,10,10 -> A5
        beat_a(2'b01, 1'b1, 1'b0); beat_a(2'b01, 1'b0, 1'b1);
        beat_a(2'b10, 1'b0, 1'b1); beat_a(2'b10, 1'b0, 1'b1);
        idle(1);
        chk("t2 dout", {24'b0, dout_a}, 32'hA5);
        rdy[0] = 1'b1; idle(1); rdy[0] = 1'b0;

        // 3: back-pressure, second word dropped
        word_a(8'h3C); word_a(8'h81);
        idle(1);
        chk("t3 dout held", {24'b0, dout_a}, 32'h3C);
        chk("t3 overflow", {31'b0, ovf[0]}, 32'h1);
`ifdef DESER_DROP_CNT_EN
        chk("t3 drop_cnt", {16'b0, dcnt[0]}, 32'h1);
`endif
        rdy[0] = 1'b1; idle(1); rdy[0] = 1'b0;
        chk("t3 valid after ready", {31'b0, valid[0]}, 32'h0);

        // 4: SOF on beat 2 restarts the word as F0
        rdy[0] = 1'b1;
        beat_a(2'b11, 1'b1, 1'b1); beat_a(2'b11, 1'b0, 1'b0);
        beat_a(2'b11, 1'b1, 1'b1);
        chk("t4 sync_err pulse", {31'b0, serr[0]}, 32'h1);
        beat_a(2'b11, 1'b0, 1'b0);
        chk("t4 sync_err cleared", {31'b0, serr[0]}, 32'h0);
        beat_a(2'b00, 1'b0, 1'b0); beat_a(2'b00, 1'b0, 1'b0);
        chk("t4 no early word", {31'b0, valid[0]}, 32'h0);
        idle(1);
        chk("t4 dout", {24'b0, dout_a}, 32'hF0);
        chk("t4 valid", {31'b0, valid[0]}, 32'h1);
`ifdef DESER_DROP_CNT_EN
        chk("t4 drop_cnt", {16'b0, dcnt[0]}, 32'h2);
`endif
        idle(1);

        // 5: reset mid-word, unframed beats ignored, then 5A
        beat_a(2'b01, 1'b1, 1'b1); beat_a(2'b01, 1'b0, 1'b0);
        rst[0] = 1'b1; idle(1); rst[0] = 1'b0;
        chk("t5 overflow cleared", {31'b0, ovf[0]}, 32'h0);
        chk("t5 dout cleared", {24'b0, dout_a}, 32'h0);
        beat_a(2'b11, 1'b0, 1'b0); beat_a(2'b10, 1'b0, 1'b0);
        beat_a(2'b00, 1'b0, 1'b0); beat_a(2'b01, 1'b0, 1'b0);
        idle(2);
        chk("t5 no output", {31'b0, valid[0]}, 32'h0);
        word_a(8'h5A);
        idle(1);
        chk("t5 dout", {24'b0, dout_a}, 32'h5A);
        idle(2);

        // 6: 24x1 LSB-first, en every other cycle, continuous framing
        rdy[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [23:0] w;
            w = exp_b[i];
            for (int k = 0; k < 24; k++) begin
                en[1] = 1'b1; din_b = w[k]; sof[1] = (k == 0); msb[1] = 1'b0;
                idle(1);
                en[1] = 1'b0; sof[1] = 1'b0;
                idle(1);
            end
        end
        idle(4);
        chk("t6 word count", words_b.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < words_b.size()) begin
                chk($sformatf("t6 word %0d", i), {8'b0, words_b[i]}, {8'b0, exp_b[i]});
            end
        end
        chk("t6 overflow", {31'b0, ovf[1]}, 32'h0);
        chk("t6 sync_err count", serr_b, 32'd0);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
